// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter packing up to wpt FU results per cycle
// Optional starvation override enabled by defining WBARB_STARVE_EN.
package wb_arbiter_pkg;
  typedef struct packed {
    logic [15:0] opid;
    logic [31:0] data;
  } exe_bundle_t;
endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int nfu    = 4,
  parameter int wpt    = 2,
  parameter int starve = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wb_stall,
  input  exe_bundle_t       req   [nfu],
  output logic [nfu-1:0]    claim,
  output exe_bundle_t       wb    [wpt]
);

  localparam int pw = (nfu > 1) ? $clog2(nfu) : 1;

  if (wpt < 1 || wpt > nfu || starve < 1) begin : g_bad_cfg
    $error("wb_arbiter: invalid parameter combination");
  end

  logic [pw-1:0]  ptr;
  logic [pw-1:0]  ptr_next;
  logic [nfu-1:0] valid;
  logic [nfu-1:0] elig;
  logic [nfu-1:0] grant;
  int             sel [wpt];
  int             gcnt;
  exe_bundle_t    wb_next [wpt];

`ifdef WBARB_STARVE_EN
  localparam int cw = $clog2(starve + 1);
  logic [cw-1:0] wait_cnt [nfu];
`endif

  always_comb begin
    int idx;
    int last;
    grant = '0;
    gcnt  = 0;
    last  = 0;
    idx   = 0;
    for (int s = 0; s < wpt; s++) sel[s] = 0;
    for (int i = 0; i < nfu; i++) begin
      valid[i] = req[i].opid[15];
      elig[i]  = valid[i] & ~rst & ~flush & ~wb_stall;
    end
`ifdef WBARB_STARVE_EN
    // Starved FUs jump the queue, lowest index first.
    for (int i = 0; i < nfu; i++) begin
      if (elig[i] && wait_cnt[i] == cw'(starve) && gcnt < wpt) begin
        grant[i]  = 1'b1;
        sel[gcnt] = i;
        gcnt      = gcnt + 1;
        last      = i;
      end
    end
`endif
    for (int k = 0; k < nfu; k++) begin
      idx = int'(ptr) + k;
      if (idx >= nfu) idx = idx - nfu;
      if (elig[idx] && !grant[idx] && gcnt < wpt) begin
        grant[idx] = 1'b1;
        sel[gcnt]  = idx;
        gcnt       = gcnt + 1;
        last       = idx;
      end
    end
    // Pointer follows the last FU in grant order, wrapping for any nfu.
    ptr_next = (last == nfu - 1) ? '0 : pw'(last + 1);
    for (int s = 0; s < wpt; s++) begin
      wb_next[s] = (s < gcnt) ? req[sel[s]] : '0;
    end
  end

  assign claim = grant;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr <= '0;
      for (int s = 0; s < wpt; s++) wb[s] <= '0;
    end else if (!wb_stall) begin
      for (int s = 0; s < wpt; s++) wb[s] <= wb_next[s];
      if (gcnt > 0) ptr <= ptr_next;
    end
  end

`ifdef WBARB_STARVE_EN
  // Counters keep running through stalls so a stalled FU can still age.
  always_ff @(posedge clk) begin
    for (int i = 0; i < nfu; i++) begin
      if (rst) begin
        wait_cnt[i] <= '0;
      end else if (valid[i] && !grant[i]) begin
        if (wait_cnt[i] != cw'(starve)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end else begin
        wait_cnt[i] <= '0;
      end
    end
  end
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter nfu, default 4: number of functional-unit requesters.
REQ-002 SHALL have parameter wpt, default 2: number of writeback ports, 1 <= wpt <= nfu.
REQ-003 SHALL have parameter starve, default 15: wait-count threshold for the starvation override.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  pipeline flush, synchronous.
REQ-007 SHALL have port wb_stall  input  1  downstream cannot accept; hold outputs.
REQ-008 SHALL have port req  input  nfu x exe_bundle_t  head result of each FU; valid when opid[15]=1.
REQ-009 SHALL have port claim  output  nfu  FU head consumed at the next edge.
REQ-010 SHALL have port wb  output  wpt x exe_bundle_t  registered writeback bundles; slot empty when all-zero.

Function
REQ-011 Grant eligibility SHALL be req[i].opid[15]=1 with rst=0, flush=0, wb_stall=0.
REQ-012 The arbiter SHALL scan FU indices (ptr+k) mod nfu, k=0..nfu-1, and grant the first wpt eligible FUs.
REQ-013 claim SHALL be combinational in the same cycle: claim[i]=1 exactly for granted FUs.
REQ-014 Granted bundles SHALL be packed into wb slots 0..g-1 in grant order at the next edge; slots g..wpt-1 SHALL be zero.
REQ-015 Latency SHALL be one cycle from claim to the bundle appearing on wb.
REQ-016 When g>0, ptr SHALL become (last granted index + 1) mod nfu; when g=0, ptr SHALL hold.
REQ-017 While wb_stall=1, claim SHALL be all-zero, wb SHALL hold its value and ptr SHALL hold.
REQ-018 While flush=1, claim SHALL be all-zero; at the next edge wb SHALL be zero and ptr SHALL be 0, regardless of wb_stall.
REQ-019 flush and wb_stall asserted together SHALL behave as flush.
REQ-020 When no requester is valid, wb SHALL be zero at the next edge (no stall) and ptr SHALL hold.
REQ-021 ptr arithmetic SHALL wrap modulo nfu for non-power-of-two nfu (e.g. nfu=3: 2 -> 0).

Reset
REQ-022 While rst=1, claim SHALL be forced to all-zero combinationally.
REQ-023 On an edge with rst=1, wb SHALL become all-zero, ptr SHALL become 0 and all wait counters SHALL become 0.
REQ-024 rst asserted mid-stall or mid-flush SHALL take priority; operation SHALL resume from ptr=0 on the first cycle after rst deasserts.

Configuration
REQ-025 When WBARB_STARVE_EN is defined, each FU SHALL have a wait counter saturating at starve.
REQ-026 With WBARB_STARVE_EN, a counter SHALL increment when its FU is valid and not granted (stall cycles included).
REQ-027 With WBARB_STARVE_EN, a counter SHALL clear when its FU is granted or invalid.
REQ-028 With WBARB_STARVE_EN, FUs whose counter equals starve SHALL be granted first, lowest index first, up to wpt.
REQ-029 With WBARB_STARVE_EN, remaining slots SHALL be filled by the round-robin scan of REQ-012, skipping FUs already granted.
REQ-030 Without WBARB_STARVE_EN, no counters SHALL exist and arbitration SHALL be pure round-robin.

Verification
REQ-031 nfu=4, wpt=2, all FUs valid continuously from reset -> claim 0011, 1100, 0011 on successive cycles, with wb carrying FU0/FU1, FU2/FU3 one cycle later.
REQ-032 Only FU2 valid, ptr=0 -> claim=0100; next cycle wb[0]=FU2 bundle, wb[1]=0, ptr=3.
REQ-033 wb holding FU0/FU1, wb_stall=1 for 3 cycles with all FUs valid -> claim=0000 and wb unchanged for 3 cycles, then claim=1100.
REQ-034 flush=1 with all FUs valid and ptr=2 -> claim=0000; next cycle wb all-zero and ptr=0.
REQ-035 starve=2, FU3 valid through a 2-cycle stall, then FU0, FU1 and FU3 valid with ptr=0 -> claim=1001 with WBARB_STARVE_EN and 0011 without it.
REQ-036 rst pulsed for 1 cycle mid-stream with ptr=3 -> claim=0000 during rst; wb zero after the edge; next grant starts at FU0.
